// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and widths for the register-file
// writeback arbiter slice.
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback, multi-cycle, decode and
// register-file write-port signals.
interface regfile_wb_arbiter_if;
  import rf_pkg::*;

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  wb_hold;
  logic                  mc_issue;
  logic [REG_ADDR_W-1:0] mc_issue_rd;
  logic                  mc_done_valid;
  logic [REG_ADDR_W-1:0] mc_done_rd;
  logic [XLEN-1:0]       mc_done_data;
  logic                  mc_done_ready;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_is_mc;
  logic                  dec_stall;
  logic                  rf_write_en;
  logic [REG_ADDR_W-1:0] rf_wr_addr;
  logic [XLEN-1:0]       rf_data_in;
  logic                  err;

  modport master (
    output wb_valid, wb_rd, wb_data,
    input  wb_hold,
    output mc_issue, mc_issue_rd,
    output mc_done_valid, mc_done_rd, mc_done_data,
    input  mc_done_ready,
    output dec_rs1, dec_rs2, dec_rd, dec_is_mc,
    input  dec_stall,
    input  rf_write_en, rf_wr_addr, rf_data_in,
    input  err
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    output wb_hold,
    input  mc_issue, mc_issue_rd,
    input  mc_done_valid, mc_done_rd, mc_done_data,
    output mc_done_ready,
    input  dec_rs1, dec_rs2, dec_rd, dec_is_mc,
    output dec_stall,
    output rf_write_en, rf_wr_addr, rf_data_in,
    output err
  );
endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-destination scoreboard: tracks in-flight
// multi-cycle results and flags decode hazards.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  drain,
  input  logic [REG_ADDR_W-1:0] drain_rd,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_is_mc,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [REG_ADDR_W-1:0] done_rd,
  output logic                  dec_stall,
  output logic                  full,
  output logic                  issue_hit,
  output logic                  wb_hit,
  output logic                  done_hit
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_nxt;
  logic                issue_nz;
  logic                inc;
  logic                dec;

  assign full      = (count == MAXC);
  assign issue_nz  = issue && (issue_rd != '0);
  assign dec       = drain && (count != '0);
  assign inc       = issue_nz && (!full || dec);
  assign issue_hit = pending[issue_rd];
  assign wb_hit    = pending[wb_rd];
  assign done_hit  = pending[done_rd];

  // Hazard check: any source or destination still in flight,
  // or no room left for another multi-cycle op.
  always_comb begin
    dec_stall = 1'b0;
    if (dec_rs1 != '0 && pending[dec_rs1]) dec_stall = 1'b1;
    if (dec_rs2 != '0 && pending[dec_rs2]) dec_stall = 1'b1;
    if (dec_rd != '0 && pending[dec_rd])   dec_stall = 1'b1;
    if (dec_is_mc && full)                 dec_stall = 1'b1;
  end

  // Next pending vector and count; a same-edge set beats clear.
  always_comb begin
    pending_nxt = pending;
    count_nxt   = count;
    if (drain) pending_nxt[drain_rd] = 1'b0;
    if (issue_nz) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
    unique case ({inc, dec})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pending_nxt;
      count   <= count_nxt;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline has priority,
// one multi-cycle result is buffered on collision.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  wb_req_t       buf_q;
  wb_req_t       buf_nxt;
  wb_req_t       out_q;
  wb_req_t       out_nxt;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_nxt;
  logic          err_q;
  logic          err_set;
  logic          ready;
  logic          accept;
  logic          pipe_win;
  logic          drain;
  logic          hold;
  logic          full;
  logic          issue_hit;
  logic          wb_hit;
  logic          done_hit;

  assign ready    = !buf_q.valid;
  assign accept   = bus.mc_done_valid && ready;
  assign pipe_win = bus.wb_valid && (bus.wb_rd != '0);
  assign drain    = buf_q.valid && !pipe_win;
  assign hold     = (starve_q >= SLIM);

  assign bus.mc_done_ready = ready;
  assign bus.wb_hold       = hold;
  assign bus.rf_write_en   = out_q.valid;
  assign bus.rf_wr_addr    = out_q.rd;
  assign bus.rf_data_in    = out_q.data;
  assign bus.err           = err_q;

  rf_scoreboard #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (bus.mc_issue),
    .issue_rd  (bus.mc_issue_rd),
    .drain     (drain),
    .drain_rd  (buf_q.rd),
    .dec_rs1   (bus.dec_rs1),
    .dec_rs2   (bus.dec_rs2),
    .dec_rd    (bus.dec_rd),
    .dec_is_mc (bus.dec_is_mc),
    .wb_rd     (bus.wb_rd),
    .done_rd   (bus.mc_done_rd),
    .dec_stall (bus.dec_stall),
    .full      (full),
    .issue_hit (issue_hit),
    .wb_hit    (wb_hit),
    .done_hit  (done_hit)
  );

  // Port select, buffer update and starvation count.
  always_comb begin
    out_nxt    = '0;
    buf_nxt    = buf_q;
    starve_nxt = starve_q;
    unique case (1'b1)
      pipe_win: begin
        out_nxt.valid = 1'b1;
        out_nxt.rd    = bus.wb_rd;
        out_nxt.data  = bus.wb_data;
      end
      drain: begin
        out_nxt.valid = (buf_q.rd != '0);
        out_nxt.rd    = buf_q.rd;
        out_nxt.data  = buf_q.data;
      end
      default: out_nxt = '0;
    endcase
    if (!out_nxt.valid) out_nxt = '0;
    if (drain) begin
      buf_nxt    = '0;
      starve_nxt = '0;
    end else if (buf_q.valid && pipe_win && !hold) begin
      starve_nxt = starve_q + 1'b1;
    end
    if (accept) begin
      buf_nxt.valid = 1'b1;
      buf_nxt.rd    = bus.mc_done_rd;
      buf_nxt.data  = bus.mc_done_data;
    end
  end

  // Protocol violations observed this cycle.
  always_comb begin
    err_set = 1'b0;
    if (bus.mc_issue && bus.mc_issue_rd != '0 && issue_hit)
      err_set = 1'b1;
    if (bus.mc_issue && full) err_set = 1'b1;
    if (accept && bus.mc_done_rd != '0 && !done_hit)
      err_set = 1'b1;
    if (bus.wb_valid && (wb_hit || hold)) err_set = 1'b1;
  end

  // Arbiter state and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q    <= '0;
      out_q    <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      buf_q    <= buf_nxt;
      out_q    <= out_nxt;
      starve_q <= starve_nxt;
      err_q    <= err_q | err_set;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for the register-file
// writeback arbiter.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.wb_valid      = 1'b0;
    bus.wb_rd         = '0;
    bus.wb_data       = '0;
    bus.mc_issue      = 1'b0;
    bus.mc_issue_rd   = '0;
    bus.mc_done_valid = 1'b0;
    bus.mc_done_rd    = '0;
    bus.mc_done_data  = '0;
    bus.dec_rs1       = '0;
    bus.dec_rs2       = '0;
    bus.dec_rd        = '0;
    bus.dec_is_mc     = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.mc_issue    = 1'b1;
    bus.mc_issue_rd = rd;
    tick();
    bus.mc_issue    = 1'b0;
    bus.mc_issue_rd = '0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_we", 32'(bus.rf_write_en), 0);
    chk("rst_addr", 32'(bus.rf_wr_addr), 0);
    chk("rst_data", bus.rf_data_in, 0);
    chk("rst_hold", 32'(bus.wb_hold), 0);
    chk("rst_stall", 32'(bus.dec_stall), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_ready", 32'(bus.mc_done_ready), 1);
    rst_n = 1'b1;
    tick();

    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 32'hDEADBEEF;
    tick();
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 32'h0BAD0BAD;
    chk("wb_we", 32'(bus.rf_write_en), 1);
    chk("wb_addr", 32'(bus.rf_wr_addr), 5);
    chk("wb_data", bus.rf_data_in, 32'hDEADBEEF);
    tick();
    bus.wb_valid = 1'b0;
    chk("wb_rd0_we", 32'(bus.rf_write_en), 0);

    issue(5'd7);
    bus.dec_rs1 = 5'd7;
    #1;
    chk("raw_stall", 32'(bus.dec_stall), 1);
    bus.mc_done_valid = 1'b1;
    bus.mc_done_rd    = 5'd7;
    bus.mc_done_data  = 32'h1234;
    #1;
    chk("mc_ready", 32'(bus.mc_done_ready), 1);
    tick();
    bus.mc_done_valid = 1'b0;
    chk("mc_e0_ready", 32'(bus.mc_done_ready), 0);
    chk("mc_e0_we", 32'(bus.rf_write_en), 0);
    chk("mc_e0_stall", 32'(bus.dec_stall), 1);
    tick();
    chk("mc_e1_we", 32'(bus.rf_write_en), 1);
    chk("mc_e1_addr", 32'(bus.rf_wr_addr), 7);
    chk("mc_e1_data", bus.rf_data_in, 32'h1234);
    chk("mc_e1_stall", 32'(bus.dec_stall), 0);
    chk("mc_e1_ready", 32'(bus.mc_done_ready), 1);
    bus.dec_rs1 = '0;

    issue(5'd3);
    bus.mc_done_valid = 1'b1;
    bus.mc_done_rd    = 5'd3;
    bus.mc_done_data  = 32'h3333;
    bus.wb_valid      = 1'b1;
    bus.wb_rd         = 5'd4;
    bus.wb_data       = 32'hAAAA;
    tick();
    idle();
    chk("col_addr1", 32'(bus.rf_wr_addr), 4);
    chk("col_data1", bus.rf_data_in, 32'hAAAA);
    chk("col_ready", 32'(bus.mc_done_ready), 0);
    tick();
    chk("col_we2", 32'(bus.rf_write_en), 1);
    chk("col_addr2", 32'(bus.rf_wr_addr), 3);
    chk("col_data2", bus.rf_data_in, 32'h3333);

    issue(5'd9);
    bus.mc_done_valid = 1'b1;
    bus.mc_done_rd    = 5'd9;
    bus.mc_done_data  = 32'h99;
    bus.wb_valid      = 1'b1;
    bus.wb_rd         = 5'd10;
    bus.wb_data       = 32'h10;
    tick();
    bus.mc_done_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("starve_7", 32'(bus.wb_hold), 0);
    tick();
    chk("starve_8", 32'(bus.wb_hold), 1);
    bus.wb_valid = 1'b0;
    tick();
    chk("drain_we", 32'(bus.rf_write_en), 1);
    chk("drain_addr", 32'(bus.rf_wr_addr), 9);
    chk("drain_data", bus.rf_data_in, 32'h99);
    chk("drain_hold", 32'(bus.wb_hold), 0);
    chk("drain_err", 32'(bus.err), 0);

    for (int r = 1; r <= 4; r++) issue(5'(r));
    bus.dec_is_mc = 1'b1;
    #1;
    chk("full_stall", 32'(bus.dec_stall), 1);
    chk("full_err0", 32'(bus.err), 0);
    issue(5'd5);
    bus.dec_is_mc = 1'b0;
    chk("ovf_err", 32'(bus.err), 1);
    tick();
    tick();
    chk("err_sticky", 32'(bus.err), 1);

    bus.mc_done_valid = 1'b1;
    bus.mc_done_rd    = 5'd1;
    bus.mc_done_data  = 32'h11;
    bus.wb_valid      = 1'b1;
    bus.wb_rd         = 5'd20;
    bus.wb_data       = 32'h20;
    tick();
    bus.mc_done_valid = 1'b0;
    chk("pre_rst_ready", 32'(bus.mc_done_ready), 0);
    bus.wb_valid = 1'b0;
    rst_n        = 1'b0;
    bus.dec_rs1  = 5'd1;
    #1;
    chk("mid_rst_we", 32'(bus.rf_write_en), 0);
    chk("mid_rst_data", bus.rf_data_in, 0);
    chk("mid_rst_ready", 32'(bus.mc_done_ready), 1);
    chk("mid_rst_err", 32'(bus.err), 0);
    chk("mid_rst_stall", 32'(bus.dec_stall), 0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_we", 32'(bus.rf_write_en), 0);
    tick();
    chk("post_rst_we2", 32'(bus.rf_write_en), 0);
    chk("post_rst_stall", 32'(bus.dec_stall), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file and shares it between two writers.
  - The in-order pipeline writeback stage has fixed priority.
  - The multi-cycle unit (divider, load miss path) completes out of order.
- Keeps a scoreboard of destinations with a multi-cycle result still in flight, and stalls decode on RAW/WAW hazards against those destinations.
- Buffers one multi-cycle result when it collides with a pipeline writeback.
- Raises a hold request to the pipeline if the buffered result starves.

Parameters:
MAX_OUTSTANDING, 4, maximum multi-cycle operations in flight (1..31)
STARVE_LIMIT, 8, cycles a buffered result may wait before wb_hold asserts (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wb_valid  in  1  pipeline writeback request
wb_rd  in  5  pipeline destination
wb_data  in  32  pipeline result
wb_hold  out  1  request pipeline to withhold wb_valid
mc_issue  in  1  multi-cycle op issued this cycle
mc_issue_rd  in  5  its destination
mc_done_valid  in  1  multi-cycle result available
mc_done_rd  in  5  result destination
mc_done_data  in  32  result data
mc_done_ready  out  1  arbiter accepts result this cycle
dec_rs1  in  5  decode source 1
dec_rs2  in  5  decode source 2
dec_rd  in  5  decode destination
dec_is_mc  in  1  decoded op is multi-cycle
dec_stall  out  1  decode must stall
rf_write_en  out  1  register file write enable (registered)
rf_wr_addr  out  5  register file write address (registered)
rf_data_in  out  32  register file write data (registered)
err  out  1  sticky protocol violation

Behaviour:
- Reset, asynchronous on rst_n low: pending[31:0]=0, outstanding count=0, buffer empty, starve counter=0, err=0.
  - All outputs are 0 during reset, except mc_done_ready=1 as a combinational function of the empty buffer.
  - Reset mid-operation discards any buffered result and all scoreboard state.
- Buffer: one entry {rd, data}. mc_done_ready = !buf_valid.
  - A transfer occurs when mc_done_valid && mc_done_ready; the entry loads at that edge.
- Write-port selection each cycle, loaded into the output registers at the edge:
  - wb_valid && wb_rd!=0 → pipeline write.
  - else buf_valid → buffer write; buffer empties at the same edge.
  - else rf_write_en=0.
- Buffer entries with rd=0 drain without asserting rf_write_en.
- A pipeline write with wb_rd=0 does not block the buffer.
- Buffer refill: it may refill at the edge it drains only if mc_done_ready was 1 that cycle. The ready is not combinationally bypassed.
- Latency:
  - Pipeline: wb_valid sampled at edge E → rf_write_en high in the cycle after E.
  - Multi-cycle: accepted at E0 → rf_write_en high after E1 at the earliest.
- Scoreboard:
  - mc_issue with mc_issue_rd!=0 sets pending[rd] and increments count.
  - A buffer drain clears pending[rd] and decrements count. An rd=0 entry decrements count only.
  - Issue and drain at the same edge: count unchanged. Set and clear of the same bit: set wins.
- dec_stall, combinational, asserts on any of:
  - pending[dec_rs1] and dec_rs1!=0;
  - pending[dec_rs2] and dec_rs2!=0;
  - pending[dec_rd] and dec_rd!=0;
  - dec_is_mc && count==MAX_OUTSTANDING.
- The pending-clear edge is the edge that registers the write. Decode then reads the new value via the combinational register-file write path in the next cycle.
- Starvation:
  - The counter increments each cycle buf_valid && the pipeline wins the port; it clears on drain.
  - When count >= STARVE_LIMIT, wb_hold=1 until the drain edge.
  - If wb_valid is asserted while wb_hold=1, the pipeline still wins and err sets.
- err sets on any of:
  - mc_issue to an already-pending rd;
  - mc_issue when count==MAX_OUTSTANDING;
  - mc_done for an rd!=0 that is not pending;
  - wb_valid with wb_rd pending.
  - err clears only on reset.

Decomposition:
- Shared package `rf_pkg`: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, typedef `wb_req_t` {logic valid; logic [4:0] rd; logic [31:0] data}.
- One natural sub-module: `rf_scoreboard`, holding the pending vector, outstanding counter and hazard compare. Buffer, mux and starvation logic stay in the top.

Test Plan:
- wb_valid, rd=5, data=0xDEADBEEF → next cycle rf_write_en=1, rf_wr_addr=5, rf_data_in=0xDEADBEEF; wb_rd=0 → rf_write_en stays 0.
- mc_issue rd=7; decode rs1=7 → dec_stall=1. mc_done rd=7 data=0x1234 with no wb → write appears 2 edges after acceptance; dec_stall drops the cycle the write is visible.
- mc_done rd=3 and wb_valid rd=4 in the same cycle → rd=4 written first, rd=3 next cycle; mc_done_ready=0 while the buffer is full.
- wb_valid held high with a buffered result, STARVE_LIMIT=8 → wb_hold=1 after 8 cycles; dropping wb_valid drains the buffer and wb_hold=0 the next cycle.
- 4 mc_issues to rd 1..4, then dec_is_mc=1 → dec_stall=1; a 5th issue → err=1 and stays 1.
- Reset asserted with pending bits set and the buffer full → all outputs 0, mc_done_ready=1, pending clear and no write after release.
